// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter that shares one multi-precision adder between NREQ requesters.
// Operands are held in registers for the whole operation; a watchdog bounds the wait for done.
module mpadder_arbiter #(
    parameter int NREQ    = 2,
    parameter int W       = 1027,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_subtract,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W:0]        rsp_result,
    output logic              rsp_error,
    output logic              add_start,
    output logic              add_subtract,
    output logic [W-1:0]      add_in_a,
    output logic [W-1:0]      add_in_b,
    input  logic [W:0]        add_result,
    input  logic              add_done
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);
    localparam logic [CW-1:0] WD_LIMIT  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   wd_q, wd_d;
    logic            add_start_q, add_start_d;
    logic            add_subtract_q, add_subtract_d;
    logic [W-1:0]    add_in_a_q, add_in_a_d;
    logic [W-1:0]    add_in_b_q, add_in_b_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W:0]      rsp_result_q, rsp_result_d;
    logic            rsp_error_q, rsp_error_d;

    logic [IW-1:0]   winner;
    logic            found;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    win_a;
    logic [W-1:0]    win_b;
    logic            win_sub;

    // Search starts just after the last served requester and wraps, so nobody starves.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        winner   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(last_grant_q) + 1 + k) % NREQ;
            cand_idx = IW'(cand);
            if (!found && req_valid[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) begin
                win_a   = req_a[i*W +: W];
                win_b   = req_b[i*W +: W];
                win_sub = req_subtract[i];
            end
        end
    end

    // The accept pulse is combinational so acceptance and operand capture share one cycle;
    // it is gated by reset so every output reads zero while reset is held.
    always_comb begin
        grant = '0;
        if (state_q == IDLE && found) begin
            grant[winner] = 1'b1;
        end
    end

    assign req_ready = resetn ? grant : '0;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        wd_d           = wd_q;
        add_start_d    = 1'b0;
        add_subtract_d = add_subtract_q;
        add_in_a_d     = add_in_a_q;
        add_in_b_d     = add_in_b_q;
        rsp_valid_d    = '0;
        rsp_result_d   = rsp_result_q;
        rsp_error_d    = rsp_error_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d        = winner;
                    add_in_a_d     = win_a;
                    add_in_b_d     = win_b;
                    add_subtract_d = win_sub;
                    add_start_d    = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the watchdog's last cycle still wins.
                if (add_done) begin
                    rsp_result_d         = add_result;
                    rsp_error_d          = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = RESP;
                end else if (wd_q == WD_LIMIT) begin
                    rsp_result_d         = '0;
                    rsp_error_d          = 1'b1;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            last_grant_q   <= LAST_INIT;
            wd_q           <= '0;
            add_start_q    <= 1'b0;
            add_subtract_q <= 1'b0;
            add_in_a_q     <= '0;
            add_in_b_q     <= '0;
            rsp_valid_q    <= '0;
            rsp_result_q   <= '0;
            rsp_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            wd_q           <= wd_d;
            add_start_q    <= add_start_d;
            add_subtract_q <= add_subtract_d;
            add_in_a_q     <= add_in_a_d;
            add_in_b_q     <= add_in_b_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_error_q    <= rsp_error_d;
        end
    end

    assign add_start    = add_start_q;
    assign add_subtract = add_subtract_q;
    assign add_in_a     = add_in_a_q;
    assign add_in_b     = add_in_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Bench for mpadder_arbiter: table of single transactions through a 2-cycle adder stub,
// plus directed sequences for timeout, round-robin, reset mid-operation and stray done pulses.
module tb_mpadder_arbiter;
    localparam int NREQ    = 2;
    localparam int W       = 1027;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_subtract;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W:0]        rsp_result;
    logic              rsp_error;
    logic              add_start;
    logic              add_subtract;
    logic [W-1:0]      add_in_a;
    logic [W-1:0]      add_in_b;
    logic [W:0]        add_result;
    logic              add_done;

    logic              stub_en;
    logic              stray_done;
    logic [1:0]        stub_sr;
    logic [W:0]        stub_res;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       sub;
        logic [W:0] exp;
    } vec_t;

    vec_t vecs[5];

    mpadder_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_subtract (req_subtract),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_error    (rsp_error),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder stand-in with latency 2: done arrives two cycles after the start pulse.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stub_sr  <= '0;
            stub_res <= '0;
        end else begin
            stub_sr <= {stub_sr[0], add_start & stub_en};
            if (add_start) begin
                stub_res <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                         : ({1'b0, add_in_a} + {1'b0, add_in_b});
            end
        end
    end

    assign add_done   = stub_sr[1] | stray_done;
    assign add_result = stub_res;

    initial begin
        #200000;
        $display("FAIL sim_watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h (low 64) hi=%0b expected %0h (low 64) hi=%0b",
                     name, act[63:0], act[W], exp[63:0], exp[W]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sub);
        req_valid[r]       = v;
        req_a[r*W +: W]    = a;
        req_b[r*W +: W]    = b;
        req_subtract[r]    = sub;
    endtask

    // Full transaction from a lone requester; called and returns at a drive point.
    task automatic run_txn(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic [W:0] exp, input logic exp_err,
                           input int exp_lat, input string tag);
        int n;
        int t0;
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        set_req(r, 1'b1, a, b, sub);
        n = 0;
        sample();
        while (req_ready == '0 && n < 20) begin
            tick();
            sample();
            n++;
        end
        check({tag, " ready"}, req_ready, oh);
        t0 = cyc;
        tick();
        set_req(r, 1'b0, ~a, ~b, ~sub);
        sample();
        check({tag, " start"}, add_start, 1'b1);
        check({tag, " in_a"}, add_in_a, a);
        check({tag, " in_b"}, add_in_b, b);
        check({tag, " subtract"}, add_subtract, sub);
        n = 0;
        tick();
        sample();
        while (rsp_valid == '0 && n < 40) begin
            tick();
            sample();
            n++;
        end
        check({tag, " rsp_valid"}, rsp_valid, oh);
        check({tag, " result"}, rsp_result, exp);
        check({tag, " error"}, rsp_error, exp_err);
        check({tag, " latency"}, cyc - t0, exp_lat);
        tick();
        sample();
        check({tag, " rsp_pulse"}, rsp_valid, '0);
        check({tag, " result_held"}, rsp_result, exp);
        tick();
    endtask

    task automatic apply_reset(input int ncyc);
        resetn = 1'b0;
        repeat (ncyc) tick();
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int g_cnt;
        int r_cnt;
        int grants[4];
        int owners[4];
        logic [W:0] results[4];
        logic [NREQ-1:0] seen_rsp;
        logic [NREQ-1:0] seen_ready;
        logic seen_start;

        vecs[0] = '{0, 5, 7, 1'b0, 12};
        vecs[1] = '{1, 7, 5, 1'b1, 2};
        vecs[2] = '{0, {W{1'b1}}, 1, 1'b0, {1'b1, {W{1'b0}}}};
        vecs[3] = '{1, 0, 1, 1'b1, {(W+1){1'b1}}};
        vecs[4] = '{0, 100, 200, 1'b0, 300};

        req_valid    = '0;
        req_subtract = '0;
        req_a        = '0;
        req_b        = '0;
        stub_en      = 1'b1;
        stray_done   = 1'b0;

        resetn = 1'b0;
        repeat (3) tick();
        sample();
        check("reset outputs", {req_ready, rsp_valid, add_start, add_subtract, rsp_error}, '0);
        check("reset rsp_result", rsp_result, '0);
        check("reset in_a", add_in_a, '0);
        tick();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp, 1'b0, 4,
                    $sformatf("vec%0d", i));
        end

        // Stray done while idle: nothing must happen.
        stray_done = 1'b1;
        sample();
        check("idle stray rsp", rsp_valid, '0);
        tick();
        stray_done = 1'b0;
        seen_rsp   = '0;
        seen_start = 1'b0;
        repeat (3) begin
            sample();
            seen_rsp   |= rsp_valid;
            seen_start |= add_start;
            tick();
        end
        check("idle stray no rsp", seen_rsp, '0);
        check("idle stray no start", seen_start, 1'b0);

        // req1 pulses for one cycle while busy and is never latched.
        set_req(0, 1'b1, 10, 20, 1'b0);
        n = 0;
        sample();
        while (req_ready == '0 && n < 20) begin
            tick();
            sample();
            n++;
        end
        check("busy ready0", req_ready, 2'b01);
        tick();
        set_req(0, 1'b0, 0, 0, 1'b0);
        set_req(1, 1'b1, 50, 50, 1'b0);
        sample();
        check("busy no ready", req_ready, '0);
        tick();
        set_req(1, 1'b0, 0, 0, 1'b0);
        n = 0;
        sample();
        while (rsp_valid == '0 && n < 40) begin
            tick();
            sample();
            n++;
        end
        check("busy rsp owner", rsp_valid, 2'b01);
        check("busy rsp result", rsp_result, 30);
        tick();
        seen_rsp   = '0;
        seen_ready = '0;
        repeat (5) begin
            sample();
            seen_rsp   |= rsp_valid;
            seen_ready |= req_ready;
            tick();
        end
        check("withdrawn not served rsp", seen_rsp, '0);
        check("withdrawn not served ready", seen_ready, '0);

        // Adder never answers: error response TIMEOUT+2 cycles after start.
        stub_en = 1'b0;
        run_txn(1, 9, 9, 1'b0, 0, 1'b1, TIMEOUT + 3, "timeout");
        stub_en = 1'b1;
        run_txn(0, 2, 3, 1'b0, 5, 1'b0, 4, "after_timeout");

        // Reset while in WAIT drops the operation.
        set_req(1, 1'b1, 8, 8, 1'b0);
        n = 0;
        sample();
        while (req_ready == '0 && n < 20) begin
            tick();
            sample();
            n++;
        end
        check("rstwait ready", req_ready, 2'b10);
        tick();
        set_req(1, 1'b0, 0, 0, 1'b0);
        tick();
        resetn = 1'b0;
        #1;
        check("rstwait outputs", {req_ready, rsp_valid, add_start, add_subtract, rsp_error}, '0);
        check("rstwait rsp_result", rsp_result, '0);
        check("rstwait in_a", add_in_a, '0);
        check("rstwait in_b", add_in_b, '0);
        tick();
        tick();
        resetn = 1'b1;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        seen_rsp = '0;
        repeat (4) begin
            sample();
            seen_rsp |= rsp_valid;
            tick();
        end
        check("rstwait stray no rsp", seen_rsp, '0);

        // Both requesters held continuously: strict alternation starting at req0.
        set_req(0, 1'b1, 1, 1, 1'b0);
        set_req(1, 1'b1, 3, 4, 1'b0);
        g_cnt = 0;
        r_cnt = 0;
        n     = 0;
        while ((g_cnt < 4 || r_cnt < 4) && n < 80) begin
            sample();
            if (req_ready != '0 && g_cnt < 4) begin
                grants[g_cnt] = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
                g_cnt++;
            end
            if (rsp_valid != '0 && r_cnt < 4) begin
                owners[r_cnt]  = (rsp_valid == 2'b01) ? 0 : (rsp_valid == 2'b10) ? 1 : 9;
                results[r_cnt] = rsp_result;
                r_cnt++;
            end
            tick();
            if (g_cnt == 4) begin
                req_valid = '0;
            end
            n++;
        end
        check("rr grant count", g_cnt, 4);
        check("rr rsp count", r_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < g_cnt) begin
                check($sformatf("rr grant%0d", i), grants[i], i % 2);
            end
            if (i < r_cnt) begin
                check($sformatf("rr owner%0d", i), owners[i], i % 2);
                check($sformatf("rr result%0d", i), results[i], (i % 2 == 0) ? 2 : 7);
            end
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpadder_arbiter.md
# mpadder_arbiter

Round-robin arbiter and sequencer that shares one multi-precision adder (`mpadder`, 1027-bit operands, 1028-bit result, start/done handshake) between several requesters, e.g. the Montgomery multiplier and the exponentiation control. It accepts one request at a time and holds the operands stable in registers for the whole adder operation. It issues a single-cycle `start`, waits for `done` under a watchdog, and returns the result to the owning requester. It sits between the requesters and the adder instance in the top-level datapath.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `W`, default 1027: operand width; the result is W+1 bits.
- `TIMEOUT`, default 15: maximum number of WAIT cycles before an error response.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester; held until accepted.
- `req_subtract` in NREQ: 1 = a−b, 0 = a+b.
- `req_a` in NREQ*W: operand a; slice i is `[i*W +: W]`.
- `req_b` in NREQ*W: operand b; same packing as `req_a`.
- `req_ready` out NREQ: one-hot, one-cycle accept pulse.
- `rsp_valid` out NREQ: one-hot, one-cycle response pulse.
- `rsp_result` out W+1: result; valid while `rsp_valid` is non-zero and held afterwards.
- `rsp_error` out 1: qualifies `rsp_valid`; 1 = watchdog timeout.
- `add_start` out 1: one-cycle start pulse to the adder.
- `add_subtract` out 1: registered subtract flag to the adder.
- `add_in_a` out W: registered operand a to the adder.
- `add_in_b` out W: registered operand b to the adder.
- `add_result` in W+1: result from the adder.
- `add_done` in 1: one-cycle done pulse from the adder.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. Reset enters IDLE.
- IDLE:
  - If any `req_valid` bit is set, select the winner by round-robin. The search starts at `last_grant+1` and wraps modulo NREQ.
  - Pulse `req_ready[winner]` and register the winner's operands and subtract flag into `add_in_a`, `add_in_b` and `add_subtract`.
  - Store the winner index in `owner` and go to ISSUE.
- ISSUE: `add_start`=1 for exactly this cycle. Clear the watchdog counter and go to WAIT.
- WAIT:
  - On `add_done`, register `add_result` into `rsp_result`, clear `rsp_error` and go to RESP.
  - Otherwise increment the watchdog counter. On the cycle the counter reaches TIMEOUT, load `rsp_result`=0 and `rsp_error`=1, then go to RESP.
- RESP: `rsp_valid[owner]`=1 for one cycle. Set `last_grant`=`owner` and go to IDLE.
- `add_done` outside WAIT is ignored; it neither latches a result nor causes a transition.
- A requester's `req_valid` may drop before it is accepted; requests are not latched before acceptance.
- After acceptance the requester's inputs may change freely. The operand registers hold until the next acceptance.
- At most one operation is in flight. There is no queueing.

## Timing
- Reset values:
  - all outputs 0;
  - FSM=IDLE, `owner`=0, watchdog counter=0;
  - `last_grant`=NREQ−1, so requester 0 has top priority after reset.
- Latency, with acceptance in cycle 0:
  - `add_start` in cycle 1;
  - `add_done` in cycle 1+L, where L is the adder latency (L=2 for the current `mpadder`);
  - `rsp_valid` in cycle 2+L;
  - earliest next acceptance in cycle 3+L.
- The operand registers are stable from cycle 1 until the next acceptance.
- An `add_done` in the same cycle the counter reaches TIMEOUT takes precedence: normal response, `rsp_error`=0.
- Simultaneous requests resolve strictly by round-robin order, with no starvation. The worst-case wait is (NREQ−1) operations.
- Reset asserted mid-operation (any state) forces IDLE immediately and clears all outputs. The in-flight request is dropped with no `rsp_valid`. The requester must re-request.
- The adder's own `resetn` is driven by the same reset. A `done` arriving after reset release is ignored because the FSM is in IDLE.

## Test plan
- Single request, req0: a=5, b=7, sub=0, L=2 → `req_ready`=01 in cycle 0, `add_start` in cycle 1, `rsp_valid`=01 in cycle 4, `rsp_result`=12, `rsp_error`=0.
- Subtraction, req1: a=7, b=5, sub=1 → `add_subtract`=1, `rsp_valid`=10, `rsp_result`=2 (bit W = 0).
- Both requesters hold `req_valid` continuously after reset → grant order 0,1,0,1. Each response goes to the matching requester with the correct sums (e.g. 1+1=2 and 3+4=7).
- Adder stub never asserts `add_done` → `rsp_valid[owner]` exactly TIMEOUT+2 cycles after `add_start`, with `rsp_error`=1 and `rsp_result`=0. The next request then completes normally.
- `resetn` pulled low during WAIT → all outputs 0 immediately. A stray `add_done` after release produces no `rsp_valid`. After re-request, req0 is granted first.
- Stray `add_done` while in IDLE, plus a `req_valid` pulse withdrawn before acceptance (FSM busy) → no response and no state change.
